// File: rtl/periph_bus_ctrl.sv
// Registered, handshaked load/store sequencer from the LSU onto the boot ROM,
// SPI, UART and GPIO peripherals, with per-transaction timeout and error count.
module periph_bus_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [XLEN/8-1:0]   req_be,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic [3:0]          dev_sel,
    output logic                dev_we,
    output logic [11:0]         dev_addr,
    output logic [XLEN-1:0]     dev_wdata,
    output logic [XLEN/8-1:0]   dev_be,
    input  logic [3:0]          dev_ack,
    input  logic [4*XLEN-1:0]   dev_rdata,
    output logic [7:0]          err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Last wait-counter value before the access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    // Full-address decode into a one-hot device select; zero means a miss.
    function automatic logic [3:0] decode_sel(input logic [XLEN-1:0] addr);
        logic [3:0] sel;
        case (addr[XLEN-1:12])
            20'h00000: sel = 4'b0001;
            20'h10000: sel = 4'b0010;
            20'h10001: sel = 4'b0100;
            20'h10002: sel = 4'b1000;
            default:   sel = 4'b0000;
        endcase
        return sel;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [3:0]         sel_r;
    logic               we_r;
    logic [11:0]        addr_r;
    logic [XLEN-1:0]    wdata_r;
    logic [XLEN/8-1:0]  be_r;
    logic [7:0]         wait_cnt_r;
    logic [XLEN-1:0]    rdata_r;
    logic               err_r;
    logic [7:0]         err_cnt_r;

    logic [3:0]         req_sel_s;
    logic               req_err_s;
    logic               ack_hit_s;
    logic [XLEN-1:0]    sel_data_s;
    logic               load_req_s;
    logic               set_rsp_s;
    logic [XLEN-1:0]    rsp_rdata_s;
    logic               rsp_err_s;

    // Request decode and selected read-data mux.
    always_comb begin
        req_sel_s  = decode_sel(req_addr);
        req_err_s  = (req_sel_s == 4'b0000) || (req_addr[1:0] != 2'b00) ||
                     (req_we && req_sel_s[0]);
        ack_hit_s  = |(dev_ack & sel_r);
        sel_data_s = {XLEN{1'b0}};
        for (int k = 0; k < 4; k++) begin
            if (sel_r[k]) begin
                sel_data_s = sel_data_s | dev_rdata[k*XLEN +: XLEN];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Next-state logic and response capture decisions.
    always_comb begin
        state_s     = state_r;
        load_req_s  = 1'b0;
        set_rsp_s   = 1'b0;
        rsp_rdata_s = {XLEN{1'b0}};
        rsp_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    load_req_s = 1'b1;
                    if (req_err_s) begin
                        state_s   = ST_RESP;
                        set_rsp_s = 1'b1;
                        rsp_err_s = 1'b1;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // An ack in the final wait cycle still completes normally.
                if (ack_hit_s) begin
                    state_s     = ST_RESP;
                    set_rsp_s   = 1'b1;
                    rsp_rdata_s = we_r ? {XLEN{1'b0}} : sel_data_s;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s   = ST_RESP;
                    set_rsp_s = 1'b1;
                    rsp_err_s = 1'b1;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request, device-side and response registers plus the error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r      <= 4'b0000;
            we_r       <= 1'b0;
            addr_r     <= 12'h000;
            wdata_r    <= {XLEN{1'b0}};
            be_r       <= {(XLEN/8){1'b0}};
            wait_cnt_r <= 8'd0;
            rdata_r    <= {XLEN{1'b0}};
            err_r      <= 1'b0;
            err_cnt_r  <= 8'd0;
        end else begin
            if (load_req_s) begin
                we_r    <= req_we;
                addr_r  <= req_addr[11:0];
                wdata_r <= req_wdata;
                be_r    <= req_be;
            end else begin
                we_r    <= we_r;
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
                be_r    <= be_r;
            end
            // Select is live only while the next state is ACCESS.
            if (state_s == ST_ACCESS) begin
                sel_r <= load_req_s ? req_sel_s : sel_r;
            end else begin
                sel_r <= 4'b0000;
            end
            if (state_r == ST_ACCESS && !ack_hit_s) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= 8'd0;
            end
            if (set_rsp_s) begin
                rdata_r <= rsp_rdata_s;
                err_r   <= rsp_err_s;
            end else begin
                rdata_r <= rdata_r;
                err_r   <= err_r;
            end
            if (state_r == ST_RESP && err_r && err_cnt_r != 8'hFF) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;
    assign dev_sel   = sel_r;
    assign dev_we    = we_r;
    assign dev_addr  = addr_r;
    assign dev_wdata = wdata_r;
    assign dev_be    = be_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: doc/periph_bus_ctrl.md
Name: periph_bus_ctrl

Overview:
Sequences single memory-mapped load/store transactions from the core's load/store unit onto the four on-chip peripherals: boot ROM, SPI, UART and GPIO. Each transaction goes through address decode, then a device access with a per-transaction timeout, then a one-cycle response back to the core. It sits between the LSU and the peripheral slaves. It replaces the purely combinational device select with a registered, handshaked controller.

Parameters:
XLEN, 32, data/address width; must be 32.
TIMEOUT, 255, maximum cycles dev_sel stays asserted waiting for dev_ack (1..255).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  LSU request valid.
req_ready  out  1  controller can accept a request.
req_we  in  1  1=store, 0=load.
req_addr  in  XLEN  byte address.
req_wdata  in  XLEN  store data.
req_be  in  XLEN/8  byte enables.
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  XLEN  load data; 0 for stores and errors.
rsp_err  out  1  decode, alignment or timeout error.
dev_sel  out  4  one-hot select; bit0 boot, bit1 spi, bit2 uart, bit3 gpio.
dev_we  out  1  write strobe qualifier.
dev_addr  out  12  word-aligned offset inside the device window (addr[11:0]).
dev_wdata  out  XLEN  write data.
dev_be  out  XLEN/8  byte enables.
dev_ack  in  4  per-device completion, same bit order as dev_sel.
dev_rdata  in  4*XLEN  read data; device k occupies [k*XLEN +: XLEN].
err_cnt  out  8  saturating count of errored transactions.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Address map, decoded on the full address:
  - boot 0x0000_0000–0x0000_0FFF, read-only.
  - spi 0x1000_0000–0x1000_0FFF.
  - uart 0x1000_1000–0x1000_1FFF.
  - gpio 0x1000_2000–0x1000_2FFF.
  - All other addresses are a decode miss.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register we/addr/wdata/be and decode.
  - Error if decode miss, or addr[1:0]!=0, or a write to boot. On error go to RESP with err=1 and rdata=0; no dev_sel is asserted.
  - Otherwise go to ACCESS.
- ACCESS:
  - req_ready=0. dev_sel is the registered one-hot select; dev_we/addr/wdata/be are driven from the registers and held stable.
  - A wait counter is cleared on entry and increments on each ACCESS cycle without ack.
  - dev_ack on the selected bit: capture the selected dev_rdata slice (forced to 0 if we=1), then go to RESP with err=0.
  - Counter reaches TIMEOUT-1 with no ack: go to RESP with err=1 and rdata=0. dev_sel is therefore asserted for at most TIMEOUT cycles.
  - Ack and timeout in the same cycle: ack wins.
  - Acks on non-selected bits are ignored in every state.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_rdata/rsp_err valid; then IDLE.
  - The core always accepts the response; there is no rsp backpressure.
  - dev_sel=0.
- Latency:
  - Request accepted in cycle N; dev_sel high in N+1.
  - Ack in N+1 gives rsp_valid in N+2, and req_ready=1 again in N+3.
  - A decode error gives rsp_valid in N+1.
- err_cnt increments by 1 on each rsp_valid with rsp_err=1 and saturates at 255.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, dev_sel=0, dev_we=0, dev_addr=0, dev_wdata=0, dev_be=0, err_cnt=0, wait counter=0.
- Reset mid-ACCESS or mid-RESP: the transaction is dropped, dev_sel=0 the cycle after rst, and no rsp_valid is emitted.
- Outputs are registered or decoded from the state only; there are no combinational paths from req_* or dev_ack to any output.

Test Plan:
- Load 0x1000_1004, uart ack in first ACCESS cycle with rdata 0xA5A5_0001 -> dev_sel=0100, dev_addr=0x004 in N+1; rsp_valid in N+2 with rdata=0xA5A5_0001, err=0.
- Store 0x1000_2008 wdata 0xDEAD_BEEF be=0xF, gpio acks after 3 wait cycles -> dev_we=1, dev_wdata held 4 cycles; rsp rdata=0, err=0.
- Load 0x2000_0000, then store 0x0000_0010, then load 0x1000_0002 -> each gives rsp err=1 in N+1, dev_sel never set; err_cnt=3.
- TIMEOUT=4, spi load with no ack -> dev_sel=0010 for exactly 4 cycles; rsp err=1, rdata=0. Repeat with ack on the 4th cycle -> err=0.
- Stray ack: boot read with dev_ack=1000 pulsed -> ignored, completes only on dev_ack bit0. Then rst during ACCESS -> dev_sel=0 next cycle, no rsp_valid, req_ready=1.
- 256 consecutive errored requests -> err_cnt saturates at 255.
